// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Round-robin, packet-granular merge of three 128-bit TLP sources (cfg completions,
// BAR completions, host-injected TLPs) into one registered transmit stream.
module pcileech_tlps128_tx_arbiter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_pcie,
    input  logic                 rst_n,

    input  logic [127:0]         tlps_cfg_rsp_tdata_i,
    input  logic [3:0]           tlps_cfg_rsp_tkeepdw_i,
    input  logic                 tlps_cfg_rsp_tlast_i,
    input  logic [8:0]           tlps_cfg_rsp_tuser_i,
    input  logic                 tlps_cfg_rsp_tvalid_i,
    input  logic                 tlps_cfg_rsp_has_data_i,
    output logic                 tlps_cfg_rsp_tready_o,

    input  logic [127:0]         tlps_bar_rsp_tdata_i,
    input  logic [3:0]           tlps_bar_rsp_tkeepdw_i,
    input  logic                 tlps_bar_rsp_tlast_i,
    input  logic [8:0]           tlps_bar_rsp_tuser_i,
    input  logic                 tlps_bar_rsp_tvalid_i,
    input  logic                 tlps_bar_rsp_has_data_i,
    output logic                 tlps_bar_rsp_tready_o,

    input  logic [127:0]         tlps_usb_tdata_i,
    input  logic [3:0]           tlps_usb_tkeepdw_i,
    input  logic                 tlps_usb_tlast_i,
    input  logic [8:0]           tlps_usb_tuser_i,
    input  logic                 tlps_usb_tvalid_i,
    input  logic                 tlps_usb_has_data_i,
    output logic                 tlps_usb_tready_o,

    output logic [127:0]         tlps_tx_tdata_o,
    output logic [3:0]           tlps_tx_tkeepdw_o,
    output logic                 tlps_tx_tlast_o,
    output logic [8:0]           tlps_tx_tuser_o,
    output logic                 tlps_tx_tvalid_o,
    output logic                 tlps_tx_has_data_o,
    input  logic                 tlps_tx_tready_i,

    output logic [CNT_WIDTH-1:0] pkt_cnt_cfg,
    output logic [CNT_WIDTH-1:0] pkt_cnt_bar,
    output logic [CNT_WIDTH-1:0] pkt_cnt_usb
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     last_q, last_d;
    logic           arm_q;

    logic [2:0]     src_valid;
    logic [1:0]     cand1, cand2, cand3;

    logic [127:0]   sel_tdata;
    logic [3:0]     sel_tkeepdw;
    logic           sel_tlast;
    logic [8:0]     sel_tuser;
    logic           sel_tvalid;
    logic           sel_tready;
    logic           accept;
    logic           pkt_done;

    logic [127:0]   out_tdata_q;
    logic [3:0]     out_tkeepdw_q;
    logic           out_tlast_q;
    logic [8:0]     out_tuser_q;
    logic           out_valid_q;

    logic [CNT_WIDTH-1:0] cnt_cfg_q, cnt_bar_q, cnt_usb_q;

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign src_valid = {tlps_usb_tvalid_i, tlps_bar_rsp_tvalid_i, tlps_cfg_rsp_tvalid_i};
    assign cand1     = rr_next(last_q);
    assign cand2     = rr_next(cand1);
    assign cand3     = rr_next(cand2);

    always_comb begin
        unique case (gnt_q)
            2'd1: begin
                sel_tdata   = tlps_bar_rsp_tdata_i;
                sel_tkeepdw = tlps_bar_rsp_tkeepdw_i;
                sel_tlast   = tlps_bar_rsp_tlast_i;
                sel_tuser   = tlps_bar_rsp_tuser_i;
                sel_tvalid  = tlps_bar_rsp_tvalid_i;
            end
            2'd2: begin
                sel_tdata   = tlps_usb_tdata_i;
                sel_tkeepdw = tlps_usb_tkeepdw_i;
                sel_tlast   = tlps_usb_tlast_i;
                sel_tuser   = tlps_usb_tuser_i;
                sel_tvalid  = tlps_usb_tvalid_i;
            end
            default: begin
                sel_tdata   = tlps_cfg_rsp_tdata_i;
                sel_tkeepdw = tlps_cfg_rsp_tkeepdw_i;
                sel_tlast   = tlps_cfg_rsp_tlast_i;
                sel_tuser   = tlps_cfg_rsp_tuser_i;
                sel_tvalid  = tlps_cfg_rsp_tvalid_i;
            end
        endcase
    end

    // arm_q holds off arbitration for the first edge after reset release
    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
            last_q  <= 2'd2;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            arm_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (arm_q) begin
                    if (src_valid[cand1]) begin
                        gnt_d   = cand1;
                        state_d = LOCK;
                    end else if (src_valid[cand2]) begin
                        gnt_d   = cand2;
                        state_d = LOCK;
                    end else if (src_valid[cand3]) begin
                        gnt_d   = cand3;
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (pkt_done) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        sel_tready            = (state_q == LOCK) && (!out_valid_q || tlps_tx_tready_i);
        accept                = sel_tready && sel_tvalid;
        pkt_done              = accept && sel_tlast;
        tlps_cfg_rsp_tready_o = sel_tready && (gnt_q == 2'd0);
        tlps_bar_rsp_tready_o = sel_tready && (gnt_q == 2'd1);
        tlps_usb_tready_o     = sel_tready && (gnt_q == 2'd2);
    end

    // A load in the same cycle as a drain replaces the beat, keeping tvalid high
    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            out_tdata_q   <= '0;
            out_tkeepdw_q <= '0;
            out_tlast_q   <= 1'b0;
            out_tuser_q   <= '0;
            out_valid_q   <= 1'b0;
        end else if (accept) begin
            out_tdata_q   <= sel_tdata;
            out_tkeepdw_q <= sel_tkeepdw;
            out_tlast_q   <= sel_tlast;
            out_tuser_q   <= sel_tuser;
            out_valid_q   <= 1'b1;
        end else if (out_valid_q && tlps_tx_tready_i) begin
            out_tdata_q   <= '0;
            out_tkeepdw_q <= '0;
            out_tlast_q   <= 1'b0;
            out_tuser_q   <= '0;
            out_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cfg_q <= '0;
            cnt_bar_q <= '0;
            cnt_usb_q <= '0;
        end else if (pkt_done) begin
            unique case (gnt_q)
                2'd1:    cnt_bar_q <= cnt_bar_q + CNT_WIDTH'(1);
                2'd2:    cnt_usb_q <= cnt_usb_q + CNT_WIDTH'(1);
                default: cnt_cfg_q <= cnt_cfg_q + CNT_WIDTH'(1);
            endcase
        end
    end

    assign tlps_tx_tdata_o    = out_tdata_q;
    assign tlps_tx_tkeepdw_o  = out_tkeepdw_q;
    assign tlps_tx_tlast_o    = out_tlast_q;
    assign tlps_tx_tuser_o    = out_tuser_q;
    assign tlps_tx_tvalid_o   = out_valid_q;
    assign tlps_tx_has_data_o = out_valid_q | tlps_cfg_rsp_has_data_i
                              | tlps_bar_rsp_has_data_i | tlps_usb_has_data_i;

    assign pkt_cnt_cfg = cnt_cfg_q;
    assign pkt_cnt_bar = cnt_bar_q;
    assign pkt_cnt_usb = cnt_usb_q;

endmodule
